// File: rtl/mem_ctrl_pkg.sv
// Shared types for the distributed-RAM port controller: controller state,
// the write-request record and the two-way round-robin pick.
package mem_ctrl_pkg;

  localparam int MEM_DATAWIDTH_DEF = 128;
  localparam int MEM_ADDRWIDTH_DEF = 6;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef struct packed {
    logic [MEM_ADDRWIDTH_DEF-1:0] addr;
    logic [MEM_DATAWIDTH_DEF-1:0] data;
    logic [MEM_DATAWIDTH_DEF-1:0] mask;
  } wr_req_t;

  // On a tie the client that was not granted last wins; last_gnt=1 means client 1.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_gnt);
    if (&req) begin
      return last_gnt ? 2'b01 : 2'b10;
    end
    return req;
  endfunction

endpackage

// File: rtl/mem_port_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the last-grant pointer only moves when the
// granted request is actually accepted downstream.
module rr_arb2
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  logic last_q, last_d;

  assign grant_o = rr_pick(req_i, last_q);

  always_comb begin
    last_d = last_q;
    if (accept_i) begin
      last_d = grant_o[1];
    end
  end

  // Pointer starts at client 1 so client 0 takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// Front-end for a simple dual-port distributed RAM: post-reset/on-demand clear
// sweep, round-robin write port, flow-controlled read port with hazard stall.
module mem_port_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int MEM_DATAWIDTH = 128,
  parameter int MEM_ADDRWIDTH = 6
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr0_valid,
  output logic                     wr0_ready,
  input  logic [MEM_ADDRWIDTH-1:0] wr0_addr,
  input  logic [MEM_DATAWIDTH-1:0] wr0_data,
  input  logic [MEM_DATAWIDTH-1:0] wr0_mask,
  input  logic                     wr1_valid,
  output logic                     wr1_ready,
  input  logic [MEM_ADDRWIDTH-1:0] wr1_addr,
  input  logic [MEM_DATAWIDTH-1:0] wr1_data,
  input  logic [MEM_DATAWIDTH-1:0] wr1_mask,
  input  logic                     rd_req_valid,
  output logic                     rd_req_ready,
  input  logic [MEM_ADDRWIDTH-1:0] rd_req_addr,
  output logic                     rd_rsp_valid,
  input  logic                     rd_rsp_ready,
  output logic [MEM_DATAWIDTH-1:0] rd_rsp_data,
  input  logic                     clear_start,
  output logic                     busy,
  output logic                     mem_ena,
  output logic [MEM_DATAWIDTH-1:0] mem_wea,
  output logic [MEM_ADDRWIDTH-1:0] mem_addra,
  output logic [MEM_DATAWIDTH-1:0] mem_dina,
  output logic                     mem_enb,
  output logic [MEM_ADDRWIDTH-1:0] mem_addrb,
  input  logic [MEM_DATAWIDTH-1:0] mem_doutb
);

  typedef struct packed {
    logic [MEM_ADDRWIDTH-1:0] addr;
    logic [MEM_DATAWIDTH-1:0] data;
    logic [MEM_DATAWIDTH-1:0] mask;
  } port_wr_t;

  localparam logic [MEM_ADDRWIDTH-1:0] LAST_ADDR = '1;

  state_e                   state_q, state_d;
  logic [MEM_ADDRWIDTH-1:0] cnt_q, cnt_d;
  logic                     ena_q, ena_d;
  logic [MEM_DATAWIDTH-1:0] wea_q, wea_d;
  logic [MEM_ADDRWIDTH-1:0] addra_q, addra_d;
  logic [MEM_DATAWIDTH-1:0] dina_q, dina_d;
  logic                     rsp_valid_q, rsp_valid_d;

  logic       run;
  logic [1:0] grant;
  logic       wr_accept;
  logic       hazard;
  logic       rd_accept;
  port_wr_t   wr_sel;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (reset_n),
    .req_i   ({wr1_valid, wr0_valid}),
    .accept_i(wr_accept),
    .grant_o (grant)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLEAR:   if (cnt_q == LAST_ADDR) state_d = RUN;
      RUN:     if (clear_start) state_d = CLEAR;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    run  = 1'b0;
    unique case (state_q)
      CLEAR:   busy = 1'b1;
      RUN:     run  = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  assign wr0_ready = grant[0] & run & ~clear_start;
  assign wr1_ready = grant[1] & run & ~clear_start;
  assign wr_accept = wr0_ready | wr1_ready;
  assign wr_sel    = grant[0] ? port_wr_t'{wr0_addr, wr0_data, wr0_mask}
                              : port_wr_t'{wr1_addr, wr1_data, wr1_mask};

  // A write still sitting in the port-A register has not reached the RAM yet.
  assign hazard       = ena_q & (addra_q == rd_req_addr);
  assign rd_req_ready = run & (~rsp_valid_q | rd_rsp_ready) & ~hazard;
  assign rd_accept    = rd_req_valid & rd_req_ready;
  assign mem_enb      = rd_accept;
  assign mem_addrb    = rd_req_addr;
  assign rd_rsp_valid = rsp_valid_q;
  assign rd_rsp_data  = mem_doutb;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
    end else if (clear_start) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    ena_d   = 1'b0;
    wea_d   = '0;
    addra_d = addra_q;
    dina_d  = dina_q;
    if (state_q == CLEAR) begin
      ena_d   = 1'b1;
      wea_d   = '1;
      addra_d = cnt_q;
      dina_d  = '0;
    end else if (wr_accept) begin
      ena_d   = 1'b1;
      wea_d   = wr_sel.mask;
      addra_d = wr_sel.addr;
      dina_d  = wr_sel.data;
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    if (rd_accept) begin
      rsp_valid_d = 1'b1;
    end else if (rd_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      ena_q       <= 1'b0;
      wea_q       <= '0;
      addra_q     <= '0;
      dina_q      <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      ena_q       <= ena_d;
      wea_q       <= wea_d;
      addra_q     <= addra_d;
      dina_q      <= dina_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign mem_ena   = ena_q;
  assign mem_wea   = wea_q;
  assign mem_addra = addra_q;
  assign mem_dina  = dina_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Bench for mem_port_ctrl: a read-first RAM model behind the DUT, a
// transaction-level reference, directed corner cases, vectors and random traffic.
module tb_mem_port_ctrl;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NW = 1 << AW;
  localparam logic [DW-1:0] ONES = '1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr0_valid, wr0_ready, wr1_valid, wr1_ready;
  logic [AW-1:0] wr0_addr, wr1_addr;
  logic [DW-1:0] wr0_data, wr1_data, wr0_mask, wr1_mask;
  logic          rd_req_valid, rd_req_ready;
  logic [AW-1:0] rd_req_addr;
  logic          rd_rsp_valid, rd_rsp_ready;
  logic [DW-1:0] rd_rsp_data;
  logic          clear_start, busy;
  logic          mem_ena;
  logic [DW-1:0] mem_wea, mem_dina;
  logic [AW-1:0] mem_addra;
  logic          mem_enb;
  logic [AW-1:0] mem_addrb;
  logic [DW-1:0] mem_doutb;

  always #5 clk = ~clk;

  mem_port_ctrl #(.MEM_DATAWIDTH(DW), .MEM_ADDRWIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr0_valid(wr0_valid), .wr0_ready(wr0_ready), .wr0_addr(wr0_addr),
    .wr0_data(wr0_data), .wr0_mask(wr0_mask),
    .wr1_valid(wr1_valid), .wr1_ready(wr1_ready), .wr1_addr(wr1_addr),
    .wr1_data(wr1_data), .wr1_mask(wr1_mask),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready), .rd_rsp_data(rd_rsp_data),
    .clear_start(clear_start), .busy(busy),
    .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addra(mem_addra), .mem_dina(mem_dina),
    .mem_enb(mem_enb), .mem_addrb(mem_addrb), .mem_doutb(mem_doutb)
  );

  // RAM behind the controller: latency 1, read-first, bit-wise write enable.
  logic [DW-1:0] ram [NW];
  always @(posedge clk) begin
    if (mem_enb) mem_doutb <= ram[mem_addrb];
    if (mem_ena) ram[mem_addra] <= (ram[mem_addra] & ~mem_wea) | (mem_dina & mem_wea);
  end

  int total = 0;
  int bad = 0;

  // Reference: array contents plus the rules for when things become visible.
  logic [DW-1:0] refMem [NW];
  bit            mClear;
  int            mSweepLeft;
  bit            mLast;
  bit            mRspPend;
  logic [DW-1:0] mRspData;
  bit            mPendValid;
  logic [AW-1:0] mPendAddr;
  logic [DW-1:0] mPendData, mPendMask;
  bit            expWr0, expWr1, expRd;

  logic          sWr0Ready, sWr1Ready, sRdReady, sRspValid, sBusy, sEna;
  logic [DW-1:0] sRspData, sWea, sDina;
  logic [AW-1:0] sAddra;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] mask;
    logic [DW-1:0] expRead;
  } vecT;
  vecT vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mClear = 1'b1;
    mSweepLeft = NW;
    mLast = 1'b1;
    mRspPend = 1'b0;
    mPendValid = 1'b0;
  endtask

  task automatic idleInputs();
    wr0_valid = 1'b0; wr1_valid = 1'b0;
    wr0_addr = '0; wr1_addr = '0;
    wr0_data = '0; wr1_data = '0; wr0_mask = '0; wr1_mask = '0;
    rd_req_valid = 1'b0; rd_req_addr = '0; rd_rsp_ready = 1'b0;
    clear_start = 1'b0;
  endtask

  task automatic checkOutput();
    bit hz;
    hz = mPendValid && (mPendAddr == rd_req_addr);
    expWr0 = !mClear && !clear_start && wr0_valid && (!wr1_valid || mLast);
    expWr1 = !mClear && !clear_start && wr1_valid && (!wr0_valid || !mLast);
    expRd  = !mClear && (!mRspPend || rd_rsp_ready) && !hz;
    sWr0Ready = wr0_ready; sWr1Ready = wr1_ready; sRdReady = rd_req_ready;
    sRspValid = rd_rsp_valid; sRspData = rd_rsp_data; sBusy = busy;
    sEna = mem_ena; sWea = mem_wea; sAddra = mem_addra; sDina = mem_dina;
    check("wr0Ready", 64'(wr0_ready), 64'(expWr0));
    check("wr1Ready", 64'(wr1_ready), 64'(expWr1));
    check("rdReqReady", 64'(rd_req_ready), 64'(expRd));
    check("busy", 64'(busy), 64'(mClear));
    check("rspValid", 64'(rd_rsp_valid), 64'(mRspPend));
    if (mRspPend) check("rspData", 64'(rd_rsp_data), 64'(mRspData));
    check("memEna", 64'(mem_ena), 64'(mPendValid));
    if (mPendValid) begin
      check("memAddra", 64'(mem_addra), 64'(mPendAddr));
      check("memWea", 64'(mem_wea), 64'(mPendMask));
      check("memDina", 64'(mem_dina & mem_wea), 64'(mPendData & mPendMask));
    end else begin
      check("memWeaIdle", 64'(mem_wea), 64'(0));
    end
    check("memEnb", 64'(mem_enb), 64'(rd_req_valid && expRd));
    if (rd_req_valid && expRd) check("memAddrb", 64'(mem_addrb), 64'(rd_req_addr));
  endtask

  task automatic modelUpdate();
    bit rdAcc;
    logic [DW-1:0] rv;
    rdAcc = rd_req_valid && expRd;
    rv = refMem[rd_req_addr];
    if (mPendValid) refMem[mPendAddr] = (refMem[mPendAddr] & ~mPendMask) | (mPendData & mPendMask);
    mPendValid = 1'b1;
    if (mClear) begin
      mPendAddr = AW'(NW - mSweepLeft); mPendData = '0; mPendMask = ONES;
    end else if (expWr0) begin
      mPendAddr = wr0_addr; mPendData = wr0_data; mPendMask = wr0_mask; mLast = 1'b0;
    end else if (expWr1) begin
      mPendAddr = wr1_addr; mPendData = wr1_data; mPendMask = wr1_mask; mLast = 1'b1;
    end else begin
      mPendValid = 1'b0;
    end
    if (rdAcc) begin
      mRspPend = 1'b1; mRspData = rv;
    end else if (rd_rsp_ready) begin
      mRspPend = 1'b0;
    end
    if (mClear) begin
      mSweepLeft--;
      if (mSweepLeft == 0) mClear = 1'b0;
    end else if (clear_start) begin
      mClear = 1'b1; mSweepLeft = NW;
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic doWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [DW-1:0] mask);
    wr0_valid = 1'b1; wr0_addr = addr; wr0_data = data; wr0_mask = mask;
    applyStimulus();
    check("wrAccept", 64'(sWr0Ready), 64'(1));
    wr0_valid = 1'b0;
    applyStimulus();
  endtask

  task automatic doRead(input logic [AW-1:0] addr, output logic [DW-1:0] data);
    rd_req_valid = 1'b1; rd_req_addr = addr; rd_rsp_ready = 1'b1;
    applyStimulus();
    check("rdAccept", 64'(sRdReady), 64'(1));
    rd_req_valid = 1'b0;
    applyStimulus();
    check("rdRspValid", 64'(sRspValid), 64'(1));
    data = sRspData;
  endtask

  task automatic checkResetValues();
    check("rstWr0Ready", 64'(wr0_ready), 64'(0));
    check("rstWr1Ready", 64'(wr1_ready), 64'(0));
    check("rstRdReady", 64'(rd_req_ready), 64'(0));
    check("rstRspValid", 64'(rd_rsp_valid), 64'(0));
    check("rstBusy", 64'(busy), 64'(1));
    check("rstEna", 64'(mem_ena), 64'(0));
    check("rstWea", 64'(mem_wea), 64'(0));
    check("rstAddra", 64'(mem_addra), 64'(0));
    check("rstDina", 64'(mem_dina), 64'(0));
    check("rstEnb", 64'(mem_enb), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [DW-1:0] rdata;
    idleInputs();
    for (int i = 0; i < NW; i++) refMem[i] = '0;
    modelReset();
    vecs[0] = '{4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[1] = '{4'd3, 32'h0000_0000, 32'h0000_00FF, 32'hFFFF_FF00};
    vecs[2] = '{4'd3, 32'h1234_5678, 32'hFFFF_0000, 32'h1234_FF00};
    vecs[3] = '{4'd8, 32'h0000_00A5, 32'hFFFF_FFFF, 32'h0000_00A5};
    vecs[4] = '{4'd8, 32'h0000_FF00, 32'h0000_FF00, 32'h0000_FFA5};
    vecs[5] = '{4'd0, 32'hCAFE_BABE, 32'hF0F0_F0F0, 32'hC0F0_B0B0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetValues();
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Sweep: port A busy for NW cycles starting one cycle after release.
    for (int k = 0; k < NW + 2; k++) begin
      applyStimulus();
      check("sweepBusy", 64'(sBusy), 64'(k < NW));
      if (k >= 1 && k <= NW) begin
        check("sweepEna", 64'(sEna), 64'(1));
        check("sweepAddr", 64'(sAddra), 64'(k - 1));
        check("sweepWea", 64'(sWea), 64'(ONES));
        check("sweepDin", 64'(sDina), 64'(0));
      end
    end
    doRead(4'd7, rdata);
    check("sweepRead7", 64'(rdata), 64'(0));

    // Round robin on ties, then a lone client 1.
    wr0_valid = 1'b1; wr1_valid = 1'b1;
    wr0_addr = 4'd10; wr1_addr = 4'd11;
    wr0_data = 32'h1010; wr1_data = 32'h1111; wr0_mask = ONES; wr1_mask = ONES;
    for (int k = 0; k < 6; k++) begin
      applyStimulus();
      check("rrGrant0", 64'(sWr0Ready), 64'(k % 2 == 0));
      check("rrGrant1", 64'(sWr1Ready), 64'(k % 2 == 1));
    end
    wr0_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus();
      check("soloGrant1", 64'(sWr1Ready), 64'(1));
    end
    wr1_valid = 1'b0;
    applyStimulus();

    for (int v = 0; v < 6; v++) begin
      doWrite(vecs[v].addr, vecs[v].data, vecs[v].mask);
      doRead(vecs[v].addr, rdata);
      check("vecRead", 64'(rdata), 64'(vecs[v].expRead));
    end

    // Response backpressure: held data, no new accept, then accept on release.
    doWrite(4'd5, 32'h5555_5555, ONES);
    doWrite(4'd6, 32'h6666_6666, ONES);
    rd_req_valid = 1'b1; rd_req_addr = 4'd5; rd_rsp_ready = 1'b1;
    applyStimulus();
    check("bpAccept", 64'(sRdReady), 64'(1));
    rd_req_addr = 4'd6; rd_rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus();
      check("bpHeldValid", 64'(sRspValid), 64'(1));
      check("bpHeldData", 64'(sRspData), 64'(32'h5555_5555));
      check("bpNoAccept", 64'(sRdReady), 64'(0));
    end
    rd_rsp_ready = 1'b1;
    applyStimulus();
    check("bpReleaseAccept", 64'(sRdReady), 64'(1));
    rd_req_valid = 1'b0;
    applyStimulus();
    check("bpNextData", 64'(sRspData), 64'(32'h6666_6666));
    applyStimulus();

    // Read right behind a write to the same address stalls one cycle.
    wr0_valid = 1'b1; wr0_addr = 4'd9; wr0_data = 32'hA5; wr0_mask = ONES;
    applyStimulus();
    check("hzWrAccept", 64'(sWr0Ready), 64'(1));
    wr0_valid = 1'b0; rd_req_valid = 1'b1; rd_req_addr = 4'd9;
    applyStimulus();
    check("hzStall", 64'(sRdReady), 64'(0));
    applyStimulus();
    check("hzAccept", 64'(sRdReady), 64'(1));
    rd_req_valid = 1'b0;
    applyStimulus();
    check("hzData", 64'(sRspData), 64'(32'hA5));

    // Same-cycle write and read: the read sees the old contents.
    wr0_valid = 1'b1; wr0_data = 32'h3C; rd_req_valid = 1'b1; rd_req_addr = 4'd9;
    applyStimulus();
    check("scWrAccept", 64'(sWr0Ready), 64'(1));
    check("scRdAccept", 64'(sRdReady), 64'(1));
    wr0_valid = 1'b0; rd_req_valid = 1'b0;
    applyStimulus();
    check("scOldData", 64'(sRspData), 64'(32'hA5));
    applyStimulus();
    doRead(4'd9, rdata);
    check("scNewData", 64'(rdata), 64'(32'h3C));

    // Clear with writers waiting and a response outstanding.
    rd_req_valid = 1'b1; rd_req_addr = 4'd3; rd_rsp_ready = 1'b0;
    applyStimulus();
    check("clrRdAccept", 64'(sRdReady), 64'(1));
    rd_req_valid = 1'b0; clear_start = 1'b1;
    wr0_valid = 1'b1; wr1_valid = 1'b1;
    wr0_addr = 4'd1; wr1_addr = 4'd2; wr0_data = ONES; wr1_data = ONES;
    applyStimulus();
    check("clrStartWr0", 64'(sWr0Ready), 64'(0));
    check("clrStartWr1", 64'(sWr1Ready), 64'(0));
    clear_start = 1'b0;
    for (int k = 0; k < NW; k++) begin
      rd_rsp_ready = (k == 2);
      applyStimulus();
      check("clrBusy", 64'(sBusy), 64'(1));
      check("clrWr0Blocked", 64'(sWr0Ready), 64'(0));
      check("clrWr1Blocked", 64'(sWr1Ready), 64'(0));
      if (k <= 2) check("clrRspValid", 64'(sRspValid), 64'(1));
      if (k == 2) check("clrRspData", 64'(sRspData), 64'(32'h1234_FF00));
    end
    wr0_valid = 1'b0; wr1_valid = 1'b0; rd_rsp_ready = 1'b0;
    applyStimulus();
    check("clrDone", 64'(sBusy), 64'(0));
    applyStimulus();
    for (int a = 0; a < NW; a++) begin
      doRead(AW'(a), rdata);
      check("clrReadZero", 64'(rdata), 64'(0));
    end

    // Reset in the middle of a sweep restarts it from address 0.
    clear_start = 1'b1;
    applyStimulus();
    clear_start = 1'b0;
    repeat (5) applyStimulus();
    reset_n = 1'b0;
    modelReset();
    @(negedge clk);
    checkResetValues();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < NW + 2; k++) begin
      applyStimulus();
      if (k == 1) check("rstSweepAddr0", 64'(sAddra), 64'(0));
    end

    for (int k = 0; k < 600; k++) begin
      wr0_valid = 1'($urandom_range(0, 1));
      wr1_valid = 1'($urandom_range(0, 1));
      wr0_addr = AW'($urandom_range(0, 3));
      wr1_addr = AW'($urandom_range(0, 3));
      wr0_data = $urandom; wr1_data = $urandom;
      wr0_mask = $urandom; wr1_mask = $urandom;
      rd_req_valid = 1'($urandom_range(0, 1));
      rd_req_addr = AW'($urandom_range(0, 3));
      rd_rsp_ready = ($urandom_range(0, 3) != 0);
      clear_start = ($urandom_range(0, 79) == 0);
      applyStimulus();
    end
    idleInputs();
    applyStimulus();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
